// File: rtl/mwc_pkg.sv
// ============================================================================
//  Package     : mwc_pkg
//  Description : Shared types and constants for the memory-write checker:
//                FSM state enum, failure codes and check-mode encodings.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mwc_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_PASS = 2'd2,
      S_FAIL = 2'd3
   } state_t;

   localparam logic [1:0] FC_NONE     = 2'd0;
   localparam logic [1:0] FC_MISMATCH = 2'd1;
   localparam logic [1:0] FC_DATA     = 2'd2;
   localparam logic [1:0] FC_TIMEOUT  = 2'd3;

   localparam logic MODE_LOOSE  = 1'b0;
   localparam logic MODE_STRICT = 1'b1;

   // Index width that never collapses to zero bits (DEPTH==1).
   function automatic int idx_width(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/mwc_exp_table.sv
// ============================================================================
//  Module      : mwc_exp_table
//  Description : DEPTH-entry table of expected {address, data} writes.
//                One synchronous write port, one asynchronous read port.
//  Ports       : clk, reset (async, active-low) - clock / table clear
//                we, widx, waddr, wdata         - entry write port
//                ridx, raddr, rdata             - entry read port
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mwc_exp_table
   import mwc_pkg::*;
#(
   parameter int AW    = 32,
   parameter int DW    = 32,
   parameter int DEPTH = 4,
   parameter int IW    = 2
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          we,
   input  logic [IW-1:0] widx,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic [IW-1:0] ridx,
   output logic [AW-1:0] raddr,
   output logic [DW-1:0] rdata
);

   logic [AW-1:0] addr_mem [DEPTH];
   logic [DW-1:0] data_mem [DEPTH];

   // Out-of-range indices (possible when DEPTH is not a power of two) are dropped.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            addr_mem[i] <= '0;
            data_mem[i] <= '0;
         end
      end else if (we && (int'(widx) < DEPTH)) begin
         addr_mem[widx] <= waddr;
         data_mem[widx] <= wdata;
      end
   end

   always_comb begin
      raddr = '0;
      rdata = '0;
      if (int'(ridx) < DEPTH) begin
         raddr = addr_mem[ridx];
         rdata = data_mem[ridx];
      end
   end

endmodule

`default_nettype wire

// File: rtl/mem_write_checker.sv
// ============================================================================
//  Module      : mem_write_checker
//  Description : Self-check monitor for the core's data-memory write bus.
//                Compares writes against an ordered table of expected writes
//                (LOOSE: foreign addresses ignored; STRICT: any deviation
//                fails), with a cycle timeout, and reports sticky pass/fail.
//  Ports       : clk, reset (async, active-low)
//                start, mode, cfg_len           - run control
//                cfg_we, cfg_idx, cfg_addr/data - expected-table programming
//                memwrite, dataadr, writedata   - observed write bus
//                busy, pass, fail, fail_code    - status
//                match_cnt, cycle_cnt           - progress counters
//                err_addr, err_data             - offending write (0 on timeout)
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_write_checker
   import mwc_pkg::*;
#(
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 1000,
   localparam int IW     = idx_width(DEPTH),
   localparam int LW     = $clog2(DEPTH + 1),
   localparam int CW     = $clog2(TIMEOUT + 1)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic          mode,
   input  logic          cfg_we,
   input  logic [IW-1:0] cfg_idx,
   input  logic [AW-1:0] cfg_addr,
   input  logic [DW-1:0] cfg_data,
   input  logic [LW-1:0] cfg_len,
   input  logic          memwrite,
   input  logic [AW-1:0] dataadr,
   input  logic [DW-1:0] writedata,
   output logic          busy,
   output logic          pass,
   output logic          fail,
   output logic [1:0]    fail_code,
   output logic [LW-1:0] match_cnt,
   output logic [CW-1:0] cycle_cnt,
   output logic [AW-1:0] err_addr,
   output logic [DW-1:0] err_data
);

   state_t        state;
   logic          run_mode;
   logic [LW-1:0] len;
   logic [IW-1:0] ptr;

   logic [AW-1:0] exp_addr;
   logic [DW-1:0] exp_data;
   logic          hit;
   logic          last;
   logic          bad;
   logic          tmo;
   logic [LW-1:0] len_clamped;

   mwc_exp_table #(
      .AW    (AW),
      .DW    (DW),
      .DEPTH (DEPTH),
      .IW    (IW)
   ) u_table (
      .clk   (clk),
      .reset (reset),
      .we    (cfg_we && (state != S_RUN)),
      .widx  (cfg_idx),
      .waddr (cfg_addr),
      .wdata (cfg_data),
      .ridx  (ptr),
      .raddr (exp_addr),
      .rdata (exp_data)
   );

   assign hit  = memwrite && (dataadr == exp_addr) && (writedata == exp_data);
   assign last = (LW'(ptr) == (len - LW'(1)));
   // A non-matching write fails in STRICT; in LOOSE only when it targets the
   // expected address (a wrong value at the right place).
   assign bad  = memwrite && !hit &&
                 ((run_mode == MODE_STRICT) || (dataadr == exp_addr));
   assign tmo  = (cycle_cnt == CW'(TIMEOUT - 1));

   assign len_clamped = (cfg_len > LW'(DEPTH)) ? LW'(DEPTH) : cfg_len;
   assign busy        = (state == S_RUN);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= S_IDLE;
         run_mode  <= MODE_LOOSE;
         len       <= '0;
         ptr       <= '0;
         pass      <= 1'b0;
         fail      <= 1'b0;
         fail_code <= FC_NONE;
         match_cnt <= '0;
         cycle_cnt <= '0;
         err_addr  <= '0;
         err_data  <= '0;
      end else begin
         case (state)
            S_RUN: begin
               if (cycle_cnt != CW'(TIMEOUT))
                  cycle_cnt <= cycle_cnt + CW'(1);
               if (hit) begin
                  ptr       <= ptr + IW'(1);
                  match_cnt <= match_cnt + LW'(1);
               end
               // Completion beats a timeout landing on the same cycle.
               if (hit && last) begin
                  state <= S_PASS;
                  pass  <= 1'b1;
               end else if (bad) begin
                  state     <= S_FAIL;
                  fail      <= 1'b1;
                  fail_code <= (run_mode == MODE_STRICT) ? FC_MISMATCH : FC_DATA;
                  err_addr  <= dataadr;
                  err_data  <= writedata;
               end else if (tmo) begin
                  state     <= S_FAIL;
                  fail      <= 1'b1;
                  fail_code <= FC_TIMEOUT;
               end
            end
            default: begin
               if (start && (cfg_len != '0)) begin
                  state     <= S_RUN;
                  run_mode  <= mode;
                  len       <= len_clamped;
                  ptr       <= '0;
                  pass      <= 1'b0;
                  fail      <= 1'b0;
                  fail_code <= FC_NONE;
                  match_cnt <= '0;
                  cycle_cnt <= '0;
                  err_addr  <= '0;
                  err_data  <= '0;
               end
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_mem_write_checker.sv
// ============================================================================
//  Module      : tb_mem_write_checker
//  Description : Scoreboard bench for mem_write_checker. Each run pushes the
//                reference outcome; a monitor pops it when pass/fail rises.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_write_checker;

   localparam int AW      = 32;
   localparam int DW      = 32;
   localparam int DEPTH   = 4;
   localparam int TIMEOUT = 16;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        mode;
   logic        cfg_we;
   logic [1:0]  cfg_idx;
   logic [31:0] cfg_addr;
   logic [31:0] cfg_data;
   logic [2:0]  cfg_len;
   logic        memwrite;
   logic [31:0] dataadr;
   logic [31:0] writedata;
   logic        busy;
   logic        pass;
   logic        fail;
   logic [1:0]  fail_code;
   logic [2:0]  match_cnt;
   logic [4:0]  cycle_cnt;
   logic [31:0] err_addr;
   logic [31:0] err_data;

   always #5 clk = ~clk;

   mem_write_checker #(
      .AW      (AW),
      .DW      (DW),
      .DEPTH   (DEPTH),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .mode      (mode),
      .cfg_we    (cfg_we),
      .cfg_idx   (cfg_idx),
      .cfg_addr  (cfg_addr),
      .cfg_data  (cfg_data),
      .cfg_len   (cfg_len),
      .memwrite  (memwrite),
      .dataadr   (dataadr),
      .writedata (writedata),
      .busy      (busy),
      .pass      (pass),
      .fail      (fail),
      .fail_code (fail_code),
      .match_cnt (match_cnt),
      .cycle_cnt (cycle_cnt),
      .err_addr  (err_addr),
      .err_data  (err_data)
   );

   typedef struct {
      logic        ps;
      logic        fl;
      logic [1:0]  code;
      int          mcnt;
      int          ccnt;
      logic [31:0] ea;
      logic [31:0] ed;
   } res_t;

   res_t        q[$];
   logic [31:0] exp_a [DEPTH];
   logic [31:0] exp_d [DEPTH];
   logic        bus_we [TIMEOUT];
   logic [31:0] bus_a  [TIMEOUT];
   logic [31:0] bus_d  [TIMEOUT];
   int          n_pass  = 0;
   int          n_total = 0;
   logic        prev_done = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_total++;
      if (act !== req)
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
      else
         n_pass++;
   endtask

   // Reference: walk the per-cycle bus trace against the ordered expectation list.
   function automatic res_t model(input logic md, input int clen);
      res_t r;
      int   len;
      int   p;
      len = (clen > DEPTH) ? DEPTH : clen;
      p   = 0;
      r.ps = 1'b0; r.fl = 1'b0; r.code = 2'd0; r.mcnt = 0; r.ccnt = 0; r.ea = '0; r.ed = '0;
      for (int k = 0; k < TIMEOUT; k++) begin
         if (bus_we[k]) begin
            if (bus_a[k] == exp_a[p] && bus_d[k] == exp_d[p]) begin
               p++;
               if (p == len) begin
                  r.ps = 1'b1; r.mcnt = p; r.ccnt = k + 1;
                  return r;
               end
            end else if (md || bus_a[k] == exp_a[p]) begin
               r.fl = 1'b1; r.code = md ? 2'd1 : 2'd2;
               r.ea = bus_a[k]; r.ed = bus_d[k]; r.mcnt = p; r.ccnt = k + 1;
               return r;
            end
         end
      end
      r.fl = 1'b1; r.code = 2'd3; r.mcnt = p; r.ccnt = TIMEOUT;
      return r;
   endfunction

   // Monitor: a run's result is presented when pass or fail rises.
   always @(negedge clk) begin
      res_t r;
      if ((pass || fail) && !prev_done) begin
         if (q.size() == 0) begin
            n_total++;
            $display("FAIL unexpected_result: got pass=%0b fail=%0b with no run pending", pass, fail);
         end else begin
            r = q.pop_front();
            check("res_pass",      pass,      r.ps);
            check("res_fail",      fail,      r.fl);
            check("res_fail_code", fail_code, r.code);
            check("res_match_cnt", match_cnt, r.mcnt);
            check("res_cycle_cnt", cycle_cnt, r.ccnt);
            check("res_err_addr",  err_addr,  r.ea);
            check("res_err_data",  err_data,  r.ed);
         end
      end
      prev_done = pass || fail;
   end

   task automatic clear_bus();
      for (int k = 0; k < TIMEOUT; k++) begin
         bus_we[k] = 1'b0; bus_a[k] = '0; bus_d[k] = '0;
      end
   endtask

   task automatic put_bus(input int k, input logic [31:0] a, input logic [31:0] d);
      bus_we[k] = 1'b1; bus_a[k] = a; bus_d[k] = d;
   endtask

   task automatic clear_exp();
      for (int i = 0; i < DEPTH; i++) begin
         exp_a[i] = '0; exp_d[i] = '0;
      end
   endtask

   task automatic do_run(input logic md, input int clen, input bit prog, input bit tamper);
      if (prog) begin
         for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            cfg_we = 1'b1; cfg_idx = 2'(i); cfg_addr = exp_a[i]; cfg_data = exp_d[i];
         end
      end
      @(negedge clk);
      cfg_we = 1'b0; mode = md; cfg_len = 3'(clen); start = 1'b1;
      q.push_back(model(md, clen));
      @(negedge clk);
      start = 1'b0;
      check("busy_after_start",   busy,        1);
      check("status_cleared",     {pass, fail}, 0);
      check("cycle_cnt_at_start", cycle_cnt,   0);
      for (int k = 0; k < TIMEOUT; k++) begin
         memwrite = bus_we[k]; dataadr = bus_a[k]; writedata = bus_d[k];
         cfg_we = 1'b0; start = 1'b0;
         if (tamper && k == 2) begin
            cfg_we = 1'b1; cfg_idx = 2'd0; cfg_addr = 32'hdead_beef; cfg_data = ~exp_d[0];
            start = 1'b1;
         end
         @(negedge clk);
      end
      memwrite = 1'b0; cfg_we = 1'b0; start = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b0; start = 1'b0; mode = 1'b0; cfg_we = 1'b0; cfg_idx = '0;
      cfg_addr = '0; cfg_data = '0; cfg_len = '0; memwrite = 1'b0;
      dataadr = '0; writedata = '0;
      clear_bus();
      clear_exp();
      repeat (3) @(negedge clk);
      check("rst_busy",      busy,      0);
      check("rst_pass",      pass,      0);
      check("rst_fail",      fail,      0);
      check("rst_fail_code", fail_code, 0);
      check("rst_match_cnt", match_cnt, 0);
      check("rst_cycle_cnt", cycle_cnt, 0);
      check("rst_err_addr",  err_addr,  0);
      check("rst_err_data",  err_data,  0);
      reset = 1'b1;

      // start with cfg_len==0 must not leave IDLE
      @(negedge clk);
      cfg_len = 3'd0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("len0_busy",   busy,         0);
      check("len0_status", {pass, fail}, 0);

      // table is zero after reset: write {0,0} completes a len=1 run
      clear_exp(); clear_bus();
      put_bus(3, 32'd0, 32'd0);
      do_run(1'b0, 1, 1'b0, 1'b0);

      // legacy single terminal write with ignored address
      clear_exp(); clear_bus();
      exp_a[0] = 32'd84; exp_d[0] = 32'd7;
      put_bus(0, 32'd80, 32'd1); put_bus(1, 32'd80, 32'd2); put_bus(2, 32'd84, 32'd7);
      do_run(1'b0, 1, 1'b1, 1'b0);

      // STRICT mismatch on second entry
      clear_exp(); clear_bus();
      exp_a[0] = 32'd20; exp_d[0] = 32'd5; exp_a[1] = 32'd24; exp_d[1] = 32'd9;
      put_bus(0, 32'd20, 32'd5); put_bus(1, 32'd28, 32'd3);
      do_run(1'b1, 2, 1'b1, 1'b0);

      // LOOSE data error
      clear_exp(); clear_bus();
      exp_a[0] = 32'd84; exp_d[0] = 32'd7;
      put_bus(0, 32'd84, 32'd6);
      do_run(1'b0, 1, 1'b1, 1'b0);

      // timeout with no writes
      clear_bus();
      do_run(1'b0, 2, 1'b1, 1'b0);

      // final match on the timeout cycle, with table write and start during RUN
      clear_exp(); clear_bus();
      exp_a[0] = 32'd40; exp_d[0] = 32'd11;
      put_bus(TIMEOUT - 1, 32'd40, 32'd11);
      do_run(1'b0, 1, 1'b1, 1'b1);
      do_run(1'b0, 1, 1'b0, 1'b0);

      // reset in the middle of a run
      clear_exp(); clear_bus();
      exp_a[0] = 32'd20; exp_d[0] = 32'd5; exp_a[1] = 32'd24; exp_d[1] = 32'd9;
      for (int i = 0; i < DEPTH; i++) begin
         @(negedge clk);
         cfg_we = 1'b1; cfg_idx = 2'(i); cfg_addr = exp_a[i]; cfg_data = exp_d[i];
      end
      @(negedge clk);
      cfg_we = 1'b0; mode = 1'b1; cfg_len = 3'd2; start = 1'b1;
      @(negedge clk);
      start = 1'b0; memwrite = 1'b1; dataadr = 32'd20; writedata = 32'd5;
      @(negedge clk);
      memwrite = 1'b0;
      @(negedge clk);
      check("pre_rst_match_cnt", match_cnt, 1);
      #2 reset = 1'b0;
      #1;
      check("midrst_busy",      busy,      0);
      check("midrst_match_cnt", match_cnt, 0);
      check("midrst_cycle_cnt", cycle_cnt, 0);
      check("midrst_status",    {pass, fail, fail_code}, 0);
      @(negedge clk);
      reset = 1'b1;

      // randomized runs
      for (int r = 0; r < 30; r++) begin
         int j;
         for (int i = 0; i < DEPTH; i++) begin
            exp_a[i] = 32'($urandom_range(0, 3)) * 32'd4;
            exp_d[i] = 32'($urandom_range(0, 3));
         end
         clear_bus();
         for (int k = 0; k < TIMEOUT; k++) begin
            if ($urandom_range(0, 1) == 1) begin
               if ($urandom_range(0, 9) < 5) begin
                  j = $urandom_range(0, DEPTH - 1);
                  put_bus(k, exp_a[j], exp_d[j]);
               end else begin
                  put_bus(k, 32'($urandom_range(0, 5)) * 32'd4, 32'($urandom_range(0, 3)));
               end
            end
         end
         do_run(1'($urandom_range(0, 1)), $urandom_range(1, 7), 1'b1, 1'b0);
      end

      check("queue_drained", q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

`default_nettype wire
